bp_be_fp_csr: RTL and testbench

Floating-point control/status endpoint for the backend: the producer of the rounding mode that the FP pipe consumes and the sink for the exception flags it emits. It resolves each instruction's rounding-mode field against the architectural `frm`. It carries exe-stage `fflags` through a flushable shadow pipeline to commit, and accrues them into the architectural `fflags`. It serves CSR accesses to `fflags`, `frm` and `fcsr`, and signals `mstatus.FS` dirty.

---
 rtl/bp_be_pkg.sv | 48 ++++
 rtl/bp_be_fflags_shadow_pipe.sv | 39 +++
 rtl/bp_be_fp_csr.sv | 129 ++++++++++++
 tb/tb_bp_be_fp_csr.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Shared definitions for the backend FP control/status endpoint:
// CSR addresses, rounding modes, exception flag layout and CSR op codes.
package bp_be_pkg;

  localparam logic [11:0] bp_fcsr_addr_fflags = 12'h001;
  localparam logic [11:0] bp_fcsr_addr_frm    = 12'h002;
  localparam logic [11:0] bp_fcsr_addr_fcsr   = 12'h003;

  typedef enum logic [2:0] {
    e_rne = 3'd0,
    e_rtz = 3'd1,
    e_rdn = 3'd2,
    e_rup = 3'd3,
    e_rmm = 3'd4,
    e_dyn = 3'd7
  } bp_be_rm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } bp_be_fflags_s;

  typedef enum logic [1:0] {
    e_csr_rw = 2'd0,
    e_csr_rs = 2'd1,
    e_csr_rc = 2'd2,
    e_csr_ro = 2'd3
  } bp_be_csr_op_e;

  // Applies a CSR op to the 8-bit fcsr image; only bits set in field_mask move.
  function automatic logic [7:0] csr_apply(input bp_be_csr_op_e op,
                                           input logic [7:0] cur,
                                           input logic [7:0] wdata,
                                           input logic [7:0] field_mask);
    logic [7:0] m;
    m = wdata & field_mask;
    case (op)
      e_csr_rw: csr_apply = (cur & ~field_mask) | m;
      e_csr_rs: csr_apply = cur | m;
      e_csr_rc: csr_apply = cur & ~m;
      default:  csr_apply = cur;
    endcase
  endfunction

endpackage

// File: rtl/bp_be_fflags_shadow_pipe.sv
// Flushable shift register carrying exe-stage exception flags to commit.
// The tail entry is exposed already qualified by the same-cycle flush.
module bp_be_fflags_shadow_pipe
  import bp_be_pkg::*;
#(
  parameter int depth_p = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       v_i,
  input  logic [4:0] flags_i,
  input  logic       flush_i,
  output logic       tail_v_o,
  output logic [4:0] tail_flags_o
);

  logic [depth_p-1:0] v_r;
  bp_be_fflags_s      flags_r [depth_p];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_r <= '0;
      for (int i = 0; i < depth_p; i++) begin
        flags_r[i] <= '0;
      end
    end else begin
      v_r[0]     <= v_i & ~flush_i;
      flags_r[0] <= flags_i;
      for (int i = 1; i < depth_p; i++) begin
        v_r[i]     <= v_r[i-1] & ~flush_i;
        flags_r[i] <= flags_r[i-1];
      end
    end
  end

  assign tail_v_o     = v_r[depth_p-1] & ~flush_i;
  assign tail_flags_o = flags_r[depth_p-1];

endmodule

// File: rtl/bp_be_fp_csr.sv
// FP control/status endpoint: rounding-mode resolution, flag accrual from the
// shadow pipe, and fflags/frm/fcsr CSR access with mstatus.FS dirty signalling.
module bp_be_fp_csr
  import bp_be_pkg::*;
#(
  parameter int pipe_depth_p     = 2,
  parameter int reg_data_width_p = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [2:0]                  instr_rm_i,
  output logic [2:0]                  frm_o,
  output logic                        rm_illegal_o,
  input  logic                        fflags_v_i,
  input  logic [4:0]                  fflags_i,
  input  logic                        flush_i,
  input  logic                        csr_v_i,
  input  logic [11:0]                 csr_addr_i,
  input  logic [1:0]                  csr_op_i,
  input  logic [reg_data_width_p-1:0] csr_data_i,
  output logic                        csr_v_o,
  output logic [reg_data_width_p-1:0] csr_data_o,
  output logic                        csr_illegal_o,
  output logic                        fs_dirty_o
);

  logic [4:0]    fflags_r;
  logic [2:0]    frm_r;
  logic          tail_v;
  bp_be_fflags_s tail_flags;
  logic [4:0]    tail_flags_raw;

  bp_be_fflags_shadow_pipe #(.depth_p(pipe_depth_p)) shadow (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .v_i         (fflags_v_i),
    .flags_i     (fflags_i),
    .flush_i     (flush_i),
    .tail_v_o    (tail_v),
    .tail_flags_o(tail_flags_raw)
  );
  assign tail_flags = bp_be_fflags_s'(tail_flags_raw);

  assign frm_o        = (instr_rm_i == e_dyn) ? frm_r : instr_rm_i;
  assign rm_illegal_o = (frm_o >= 3'd5);

  logic          addr_legal;
  logic [7:0]    fcsr_cur;
  logic [7:0]    field_mask;
  logic [7:0]    wdata;
  logic [7:0]    fcsr_op;
  logic [7:0]    read_val;
  logic [4:0]    accrue_flags;
  logic [4:0]    fflags_n;
  logic [2:0]    frm_n;
  logic          csr_dirty;
  logic          accrue_dirty;
  bp_be_csr_op_e op;
  logic          unused_data_hi;

  assign op             = bp_be_csr_op_e'(csr_op_i);
  assign fcsr_cur       = {frm_r, fflags_r};
  assign unused_data_hi = ^csr_data_i[reg_data_width_p-1:8];

  // Every access is mapped onto the 8-bit fcsr image so one op path serves all three CSRs.
  always_comb begin
    addr_legal = 1'b1;
    field_mask = 8'h00;
    wdata      = 8'h00;
    read_val   = 8'h00;
    case (csr_addr_i)
      bp_fcsr_addr_fflags: begin
        field_mask = 8'h1F;
        wdata      = {3'b000, csr_data_i[4:0]};
        read_val   = {3'b000, fflags_r};
      end
      bp_fcsr_addr_frm: begin
        field_mask = 8'hE0;
        wdata      = {csr_data_i[2:0], 5'b00000};
        read_val   = {5'b00000, frm_r};
      end
      bp_fcsr_addr_fcsr: begin
        field_mask = 8'hFF;
        wdata      = csr_data_i[7:0];
        read_val   = fcsr_cur;
      end
      default: addr_legal = 1'b0;
    endcase
  end

  always_comb begin
    fcsr_op   = fcsr_cur;
    csr_dirty = 1'b0;
    if (csr_v_i && addr_legal) begin
      fcsr_op = csr_apply(op, fcsr_cur, wdata, field_mask);
      case (op)
        e_csr_rw: csr_dirty = 1'b1;
        e_csr_rs, e_csr_rc: csr_dirty = |(wdata & field_mask);
        default: csr_dirty = 1'b0;
      endcase
    end
  end

  // CSR op lands first, then the committing tail flags are ORed on top.
  assign accrue_flags = tail_v ? tail_flags : 5'b00000;
  assign accrue_dirty = tail_v && (tail_flags != '0);
  assign fflags_n     = fcsr_op[4:0] | accrue_flags;
  assign frm_n        = fcsr_op[7:5];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fflags_r      <= '0;
      frm_r         <= e_rne;
      csr_v_o       <= 1'b0;
      csr_data_o    <= '0;
      csr_illegal_o <= 1'b0;
      fs_dirty_o    <= 1'b0;
    end else begin
      fflags_r      <= fflags_n;
      frm_r         <= frm_n;
      csr_v_o       <= csr_v_i;
      csr_data_o    <= (csr_v_i && addr_legal)
                       ? {{(reg_data_width_p-8){1'b0}}, read_val} : '0;
      csr_illegal_o <= csr_v_i && !addr_legal;
      fs_dirty_o    <= csr_dirty || accrue_dirty;
    end
  end

endmodule

// File: tb/tb_bp_be_fp_csr.sv
// Directed bench for bp_be_fp_csr at default parameters (depth 2, 64-bit data).
module tb_bp_be_fp_csr;

  logic        clk_i;
  logic        reset_i;
  logic [2:0]  instr_rm_i;
  logic [2:0]  frm_o;
  logic        rm_illegal_o;
  logic        fflags_v_i;
  logic [4:0]  fflags_i;
  logic        flush_i;
  logic        csr_v_i;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [63:0] csr_data_i;
  logic        csr_v_o;
  logic [63:0] csr_data_o;
  logic        csr_illegal_o;
  logic        fs_dirty_o;

  int total = 0;
  int bad   = 0;

  bp_be_fp_csr #(.pipe_depth_p(2), .reg_data_width_p(64)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .instr_rm_i   (instr_rm_i),
    .frm_o        (frm_o),
    .rm_illegal_o (rm_illegal_o),
    .fflags_v_i   (fflags_v_i),
    .fflags_i     (fflags_i),
    .flush_i      (flush_i),
    .csr_v_i      (csr_v_i),
    .csr_addr_i   (csr_addr_i),
    .csr_op_i     (csr_op_i),
    .csr_data_i   (csr_data_i),
    .csr_v_o      (csr_v_o),
    .csr_data_o   (csr_data_o),
    .csr_illegal_o(csr_illegal_o),
    .fs_dirty_o   (fs_dirty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic csr_cycle(input logic [11:0] a, input logic [1:0] o, input logic [63:0] d);
    csr_v_i    = 1'b1;
    csr_addr_i = a;
    csr_op_i   = o;
    csr_data_i = d;
    tick();
    csr_v_i    = 1'b0;
    csr_data_i = '0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    tick();
    tick();
    total++; if (csr_v_o !== 1'b0) begin bad++; $display("FAIL reset_csr_v got=%0b want=0", csr_v_o); end
    total++; if (csr_data_o !== 64'h0) begin bad++; $display("FAIL reset_csr_data got=%0h want=0", csr_data_o); end
    total++; if (csr_illegal_o !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%0b want=0", csr_illegal_o); end
    total++; if (fs_dirty_o !== 1'b0) begin bad++; $display("FAIL reset_dirty got=%0b want=0", fs_dirty_o); end
    instr_rm_i = 3'd7;
    #1;
    total++; if (frm_o !== 3'd0) begin bad++; $display("FAIL reset_frm_dyn got=%0d want=0", frm_o); end
    total++; if (rm_illegal_o !== 1'b0) begin bad++; $display("FAIL reset_rm_illegal got=%0b want=0", rm_illegal_o); end
    reset_i = 1'b0;
    tick();
    csr_cycle(12'h003, 2'd3, 64'h0);
    total++; if (csr_v_o !== 1'b1) begin bad++; $display("FAIL reset_fcsr_rd_v got=%0b want=1", csr_v_o); end
    total++; if (csr_data_o !== 64'h0) begin bad++; $display("FAIL reset_fcsr_rd got=%0h want=0", csr_data_o); end
    total++; if (fs_dirty_o !== 1'b0) begin bad++; $display("FAIL reset_fcsr_rd_dirty got=%0b want=0", fs_dirty_o); end
    tick();
    total++; if (csr_v_o !== 1'b0) begin bad++; $display("FAIL resp_one_cycle got=%0b want=0", csr_v_o); end
  endtask

  task automatic test_rm;
    csr_cycle(12'h002, 2'd0, 64'h2);
    total++; if (fs_dirty_o !== 1'b1) begin bad++; $display("FAIL frm_rw_dirty got=%0b want=1", fs_dirty_o); end
    total++; if (csr_data_o !== 64'h0) begin bad++; $display("FAIL frm_rw_old got=%0h want=0", csr_data_o); end
    instr_rm_i = 3'd7; #1;
    total++; if (frm_o !== 3'd2) begin bad++; $display("FAIL rm_dyn got=%0d want=2", frm_o); end
    instr_rm_i = 3'd1; #1;
    total++; if (frm_o !== 3'd1) begin bad++; $display("FAIL rm_static got=%0d want=1", frm_o); end
    total++; if (rm_illegal_o !== 1'b0) begin bad++; $display("FAIL rm_static_legal got=%0b want=0", rm_illegal_o); end
    instr_rm_i = 3'd5; #1;
    total++; if (rm_illegal_o !== 1'b1) begin bad++; $display("FAIL rm5_illegal got=%0b want=1", rm_illegal_o); end
    instr_rm_i = 3'd4; #1;
    total++; if (rm_illegal_o !== 1'b0) begin bad++; $display("FAIL rm4_legal got=%0b want=0", rm_illegal_o); end
    @(negedge clk_i);
    csr_cycle(12'h002, 2'd0, 64'h6);
    instr_rm_i = 3'd7; #1;
    total++; if (frm_o !== 3'd6) begin bad++; $display("FAIL rm_dyn6 got=%0d want=6", frm_o); end
    total++; if (rm_illegal_o !== 1'b1) begin bad++; $display("FAIL rm_dyn6_illegal got=%0b want=1", rm_illegal_o); end
    @(negedge clk_i);
    csr_cycle(12'h002, 2'd0, 64'h0);
    tick();
  endtask

  task automatic test_accrue;
    fflags_v_i = 1'b1; fflags_i = 5'b10001;
    tick();
    fflags_v_i = 1'b0; fflags_i = 5'b00000;
    tick();
    total++; if (fs_dirty_o !== 1'b0) begin bad++; $display("FAIL accrue_early_dirty got=%0b want=0", fs_dirty_o); end
    csr_v_i = 1'b1; csr_addr_i = 12'h001; csr_op_i = 2'd3;
    tick();
    total++; if (csr_data_o !== 64'h0) begin bad++; $display("FAIL accrue_pre_rd got=%0h want=0", csr_data_o); end
    total++; if (fs_dirty_o !== 1'b1) begin bad++; $display("FAIL accrue_dirty got=%0b want=1", fs_dirty_o); end
    tick();
    csr_v_i = 1'b0;
    total++; if (csr_data_o !== 64'h11) begin bad++; $display("FAIL accrue_rd got=%0h want=11", csr_data_o); end
    total++; if (fs_dirty_o !== 1'b0) begin bad++; $display("FAIL accrue_dirty_pulse got=%0b want=0", fs_dirty_o); end
  endtask

  task automatic test_flush;
    csr_cycle(12'h001, 2'd0, 64'h0);
    tick();
    fflags_v_i = 1'b1; fflags_i = 5'b10001;
    tick();
    fflags_v_i = 1'b0; fflags_i = 5'b00000; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (fs_dirty_o !== 1'b0) begin bad++; $display("FAIL flush_dirty%0d got=%0b want=0", i, fs_dirty_o); end
    end
    csr_cycle(12'h001, 2'd3, 64'h0);
    total++; if (csr_data_o !== 64'h0) begin bad++; $display("FAIL flush_rd got=%0h want=0", csr_data_o); end
  endtask

  task automatic test_rc_accrue;
    csr_cycle(12'h001, 2'd0, 64'h1F);
    fflags_v_i = 1'b1; fflags_i = 5'b00001;
    tick();
    fflags_v_i = 1'b0; fflags_i = 5'b00000;
    tick();
    csr_cycle(12'h001, 2'd2, 64'h3);
    total++; if (csr_data_o !== 64'h1F) begin bad++; $display("FAIL rc_accrue_resp got=%0h want=1f", csr_data_o); end
    total++; if (fs_dirty_o !== 1'b1) begin bad++; $display("FAIL rc_accrue_dirty got=%0b want=1", fs_dirty_o); end
    csr_cycle(12'h001, 2'd3, 64'h0);
    total++; if (csr_data_o !== 64'h1D) begin bad++; $display("FAIL rc_accrue_rd got=%0h want=1d", csr_data_o); end
  endtask

  task automatic test_fcsr;
    csr_cycle(12'h003, 2'd0, 64'hE5);
    total++; if (csr_data_o !== 64'h1D) begin bad++; $display("FAIL fcsr_rw_old got=%0h want=1d", csr_data_o); end
    csr_cycle(12'h003, 2'd3, 64'h0);
    total++; if (csr_data_o !== 64'hE5) begin bad++; $display("FAIL fcsr_rd got=%0h want=e5", csr_data_o); end
    csr_cycle(12'h001, 2'd1, 64'h2);
    total++; if (csr_data_o !== 64'h05) begin bad++; $display("FAIL fflags_rs_old got=%0h want=5", csr_data_o); end
    csr_cycle(12'h002, 2'd2, 64'h3);
    total++; if (csr_data_o !== 64'h07) begin bad++; $display("FAIL frm_rc_old got=%0h want=7", csr_data_o); end
    csr_cycle(12'h001, 2'd1, 64'hFFFF_FF00);
    total++; if (fs_dirty_o !== 1'b0) begin bad++; $display("FAIL rs_zero_mask_dirty got=%0b want=0", fs_dirty_o); end
    csr_cycle(12'h003, 2'd3, 64'h0);
    total++; if (csr_data_o !== 64'h87) begin bad++; $display("FAIL fcsr_after_ops got=%0h want=87", csr_data_o); end
    csr_cycle(12'h002, 2'd0, 64'hFFFF_FFFF_FFFF_FFF9);
    instr_rm_i = 3'd7; #1;
    total++; if (frm_o !== 3'd1) begin bad++; $display("FAIL frm_upper_ignored got=%0d want=1", frm_o); end
    @(negedge clk_i);
    csr_cycle(12'h003, 2'd3, 64'h0);
    total++; if (csr_data_o !== 64'h27) begin bad++; $display("FAIL fcsr_rd2 got=%0h want=27", csr_data_o); end
  endtask

  task automatic test_illegal;
    csr_cycle(12'h004, 2'd0, 64'hFF);
    total++; if (csr_illegal_o !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%0b want=1", csr_illegal_o); end
    total++; if (csr_data_o !== 64'h0) begin bad++; $display("FAIL illegal_data got=%0h want=0", csr_data_o); end
    total++; if (csr_v_o !== 1'b1) begin bad++; $display("FAIL illegal_v got=%0b want=1", csr_v_o); end
    total++; if (fs_dirty_o !== 1'b0) begin bad++; $display("FAIL illegal_dirty got=%0b want=0", fs_dirty_o); end
    csr_cycle(12'h003, 2'd3, 64'h0);
    total++; if (csr_data_o !== 64'h27) begin bad++; $display("FAIL illegal_no_write got=%0h want=27", csr_data_o); end
    total++; if (csr_illegal_o !== 1'b0) begin bad++; $display("FAIL legal_flag got=%0b want=0", csr_illegal_o); end
  endtask

  task automatic test_back_to_back;
    csr_v_i = 1'b1; csr_addr_i = 12'h002; csr_op_i = 2'd0; csr_data_i = 64'h5;
    tick();
    total++; if (csr_data_o !== 64'h1) begin bad++; $display("FAIL b2b_0 got=%0h want=1", csr_data_o); end
    total++; if (fs_dirty_o !== 1'b1) begin bad++; $display("FAIL b2b_dirty got=%0b want=1", fs_dirty_o); end
    csr_op_i = 2'd3; csr_data_i = 64'h0;
    tick();
    total++; if (csr_data_o !== 64'h5) begin bad++; $display("FAIL b2b_1 got=%0h want=5", csr_data_o); end
    csr_addr_i = 12'h001;
    tick();
    total++; if (csr_data_o !== 64'h7) begin bad++; $display("FAIL b2b_2 got=%0h want=7", csr_data_o); end
    csr_v_i = 1'b0;
    tick();
    total++; if (csr_v_o !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b want=0", csr_v_o); end
  endtask

  task automatic test_reset_midpipe;
    fflags_v_i = 1'b1; fflags_i = 5'b11111;
    csr_v_i = 1'b1; csr_addr_i = 12'h003; csr_op_i = 2'd3;
    tick();
    fflags_v_i = 1'b0; fflags_i = 5'b00000; csr_v_i = 1'b0;
    total++; if (csr_data_o !== 64'hA7) begin bad++; $display("FAIL pre_reset_rd got=%0h want=a7", csr_data_o); end
    reset_i = 1'b1;
    #1;
    total++; if (csr_v_o !== 1'b0) begin bad++; $display("FAIL async_reset_v got=%0b want=0", csr_v_o); end
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (fs_dirty_o !== 1'b0) begin bad++; $display("FAIL midpipe_dirty%0d got=%0b want=0", i, fs_dirty_o); end
    end
    csr_cycle(12'h003, 2'd3, 64'h0);
    total++; if (csr_data_o !== 64'h0) begin bad++; $display("FAIL midpipe_fcsr got=%0h want=0", csr_data_o); end
  endtask

  initial begin
    reset_i    = 1'b1;
    instr_rm_i = 3'd0;
    fflags_v_i = 1'b0;
    fflags_i   = 5'b0;
    flush_i    = 1'b0;
    csr_v_i    = 1'b0;
    csr_addr_i = 12'h0;
    csr_op_i   = 2'd0;
    csr_data_i = 64'h0;
    @(negedge clk_i);
    test_reset();
    test_rm();
    test_accrue();
    test_flush();
    test_rc_accrue();
    test_fcsr();
    test_illegal();
    test_back_to_back();
    test_reset_midpipe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
